// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port 64-bit data memory among four requesters, with bounded lock bursts.
// Grant in 0 cycles, read data 1 cycle later; an ungranted requester just keeps req asserted (no other backpressure).
module dmem_rr_arbiter #(
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [0:3]    req,
   input  logic [0:3]    wren,
   input  logic [0:3]    lock,
   input  logic [0:127]  addr,
   input  logic [0:255]  wdata,
   output logic [0:3]    gnt,
   output logic [0:3]    rvalid,
   output logic [0:63]   rdata,
   output logic          mem_En,
   output logic          mem_WrEn,
   output logic [0:31]   mem_addr,
   output logic [0:63]   mem_d_in,
   input  logic [0:63]   mem_d_out
);

   typedef enum logic {ARB, LOCKED} state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

   state_t      state;
   logic [1:0]  ptr;
   logic [1:0]  owner;
   logic [3:0]  burst_cnt;
   logic [3:0]  burst_nxt;

   logic        owner_hold;
   logic [1:0]  cand;
   logic [1:0]  arb_idx;
   logic        arb_any;
   logic [1:0]  win;
   logic        win_vld;

   // Descending scan so the candidate closest to ptr is the last one written.
   always_comb begin
      cand    = '0;
      arb_idx = ptr;
      arb_any = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr + 2'(k);
         if (req[cand]) begin
            arb_idx = cand;
            arb_any = 1'b1;
         end
      end
   end

   assign owner_hold = (state == LOCKED) && req[owner];
   assign win        = owner_hold ? owner : arb_idx;
   assign win_vld    = !reset && (owner_hold || arb_any);
   assign burst_nxt  = burst_cnt + 4'd1;

   always_comb begin
      gnt = '0;
      if (win_vld)
         gnt[win] = 1'b1;
   end

   assign mem_En   = win_vld;
   assign mem_WrEn = win_vld && wren[win];
   assign mem_addr = win_vld ? addr[{win, 5'd0} +: 32]  : '0;
   assign mem_d_in = win_vld ? wdata[{win, 6'd0} +: 64] : '0;

   // Memory data is already aligned with rvalid, so it only needs gating.
   assign rdata = (|rvalid) ? mem_d_out : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ARB;
         ptr       <= 2'd0;
         owner     <= 2'd0;
         burst_cnt <= 4'd0;
         rvalid    <= '0;
      end else begin
         rvalid <= (win_vld && !wren[win]) ? gnt : '0;
         if (owner_hold) begin
            burst_cnt <= burst_nxt;
            if (!lock[owner] || burst_nxt == MAX_CNT)
               state <= ARB;
         end else if (arb_any) begin
            // ptr already sits at owner+1 while locked, so only arbitrated grants move it.
            ptr <= arb_idx + 2'd1;
            if (lock[arb_idx] && MAX_BURST > 1) begin
               state     <= LOCKED;
               owner     <= arb_idx;
               burst_cnt <= 4'd1;
            end else begin
               state <= ARB;
            end
         end else begin
            state <= ARB;
         end
      end
   end

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Bench for dmem_rr_arbiter: directed scenarios plus random traffic against a grant-history reference model.
module tb_dmem_rr_arbiter;

   localparam int MAX_BURST = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [0:3]    req, wren, lock;
   logic [0:127]  addr;
   logic [0:255]  wdata;
   logic [0:3]    gnt, rvalid;
   logic [0:63]   rdata;
   logic          mem_En, mem_WrEn;
   logic [0:31]   mem_addr;
   logic [0:63]   mem_d_in;
   logic [0:63]   mem_d_out = '0;

   int tests = 0;
   int fails = 0;

   dmem_rr_arbiter #(.MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .reset(reset), .req(req), .wren(wren), .lock(lock),
      .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .mem_En(mem_En), .mem_WrEn(mem_WrEn), .mem_addr(mem_addr),
      .mem_d_in(mem_d_in), .mem_d_out(mem_d_out)
   );

   always #5 clk = ~clk;

   // Environment memory: answers the DUT's port one cycle after a read.
   logic [63:0] env_mem [logic [31:0]];
   always @(posedge clk) begin
      if (mem_En) begin
         if (mem_WrEn)
            env_mem[mem_addr] = mem_d_in;
         else
            mem_d_out <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : {mem_addr, ~mem_addr};
      end
   end

   // Reference model: who was granted last, how long the current locked run is.
   logic [63:0] ref_mem [logic [31:0]];
   int          m_last = 3, m_run = 0, m_w = -1, m_rd_who = 0;
   bit          m_prio = 0, m_rd_pend = 0;
   logic [63:0] m_rd_data = '0;
   logic [0:3]  e_gnt, e_rvalid;
   logic        e_en, e_we;
   logic [31:0] e_addr;
   logic [63:0] e_din, e_rdata;

   function automatic logic [31:0] addr_of(int i);
      return addr[32*i +: 32];
   endfunction

   task automatic model_comb();
      if (reset) begin
         m_last = 3; m_prio = 0; m_run = 0; m_rd_pend = 0;
      end
      m_w = -1;
      if (!reset) begin
         if (m_prio && req[m_last])
            m_w = m_last;
         else
            for (int k = 1; k <= 4; k++)
               if (m_w < 0 && req[(m_last + k) % 4]) m_w = (m_last + k) % 4;
      end
      e_gnt = '0; e_en = 0; e_we = 0; e_addr = '0; e_din = '0;
      if (m_w >= 0) begin
         e_gnt[m_w] = 1'b1;
         e_en  = 1'b1;
         e_we  = wren[m_w];
         e_addr = addr_of(m_w);
         e_din = wdata[64*m_w +: 64];
      end
      e_rvalid = '0; e_rdata = '0;
      if (m_rd_pend) begin
         e_rvalid[m_rd_who] = 1'b1;
         e_rdata = m_rd_data;
      end
   endtask

   task automatic model_clock();
      m_rd_pend = 0;
      if (m_w >= 0) begin
         m_run  = (m_prio && m_w == m_last) ? m_run + 1 : 1;
         m_prio = lock[m_w] && (m_run < MAX_BURST);
         m_last = m_w;
         if (wren[m_w]) begin
            ref_mem[e_addr] = e_din;
         end else begin
            m_rd_pend = 1;
            m_rd_who  = m_w;
            m_rd_data = ref_mem.exists(e_addr) ? ref_mem[e_addr] : {e_addr, ~e_addr};
         end
      end else begin
         m_prio = 0;
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 2ns later.
   task automatic settle();
      #2;
      model_comb();
   endtask

   task automatic advance();
      @(posedge clk);
      model_comb();
      model_clock();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1; req = '0; wren = '0; lock = '0;
      repeat (2) advance();
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1; req = 4'b1111; wren = '0; lock = '0;
      @(negedge clk);
      settle();
      tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      tests++; if (mem_En !== 1'b0) begin fails++; $display("FAIL reset_mem_En: got %b want 0", mem_En); end
      tests++; if (rvalid !== 4'b0000) begin fails++; $display("FAIL reset_rvalid: got %b want 0000", rvalid); end
      tests++; if (rdata !== 64'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      advance();
      reset = 0;
   endtask

   task automatic test_rotation();
      logic [0:3] exp_g [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
      int         exp_i [5] = '{0, 1, 2, 3, 0};
      req = 4'b1111; wren = '0; lock = '0;
      for (int c = 0; c < 5; c++) begin
         settle();
         tests++; if (gnt !== exp_g[c]) begin fails++; $display("FAIL rot_gnt[%0d]: got %b want %b", c, gnt, exp_g[c]); end
         tests++; if (mem_addr !== addr_of(exp_i[c])) begin fails++; $display("FAIL rot_addr[%0d]: got %h want %h", c, mem_addr, addr_of(exp_i[c])); end
         advance();
      end
   endtask

   task automatic test_single_read();
      env_mem[32'h40] = 64'hDEAD_BEEF_0000_0001;
      ref_mem[32'h40] = 64'hDEAD_BEEF_0000_0001;
      addr[64 +: 32] = 32'h40;
      req = 4'b0010; wren = '0; lock = '0;
      settle();
      tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL rd_gnt: got %b want 0010", gnt); end
      advance();
      req = '0;
      settle();
      tests++; if (rvalid !== 4'b0010) begin fails++; $display("FAIL rd_rvalid: got %b want 0010", rvalid); end
      tests++; if (rdata !== 64'hDEAD_BEEF_0000_0001) begin fails++; $display("FAIL rd_rdata: got %h want deadbeef00000001", rdata); end
      advance();
      settle();
      tests++; if (rvalid !== 4'b0000) begin fails++; $display("FAIL rd_rvalid_clear: got %b want 0000", rvalid); end
   endtask

   task automatic test_write();
      wdata[192 +: 64] = 64'h1234;
      req = 4'b0001; wren = 4'b0001; lock = '0;
      settle();
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL wr_gnt: got %b want 0001", gnt); end
      tests++; if ({mem_En, mem_WrEn} !== 2'b11) begin fails++; $display("FAIL wr_en: got %b%b want 11", mem_En, mem_WrEn); end
      tests++; if (mem_d_in !== 64'h1234) begin fails++; $display("FAIL wr_d_in: got %h want 1234", mem_d_in); end
      advance();
      req = '0; wren = '0;
      settle();
      tests++; if (rvalid !== 4'b0000) begin fails++; $display("FAIL wr_rvalid: got %b want 0000", rvalid); end
   endtask

   task automatic test_lock_burst();
      logic [0:3] exp_g [8] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000,
                                4'b0100, 4'b0010, 4'b0001, 4'b1000};
      do_reset();
      req = 4'b1111; wren = 4'b1111; lock = 4'b1000;
      for (int c = 0; c < 8; c++) begin
         settle();
         tests++; if (gnt !== exp_g[c]) begin fails++; $display("FAIL burst_gnt[%0d]: got %b want %b", c, gnt, exp_g[c]); end
         advance();
      end
   endtask

   task automatic test_lock_release();
      do_reset();
      req = 4'b0100; lock = 4'b0100; wren = '0;
      settle();
      tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL rel_lock_gnt: got %b want 0100", gnt); end
      advance();
      req = 4'b0001;
      settle();
      tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL rel_drop_gnt: got %b want 0001", gnt); end
      advance();
      req = 4'b1101; lock = 4'b0001;
      settle();
      tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL rel_ptr_gnt: got %b want 1000", gnt); end
      advance();
      req = 4'b1111; lock = '0;
      settle();
      tests++; if (gnt !== 4'b0100) begin fails++; $display("FAIL rel_ignored_lock_gnt: got %b want 0100", gnt); end
      advance();
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      req = 4'b1000; wren = '0; lock = '0;
      settle();
      tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL mid_gnt: got %b want 1000", gnt); end
      advance();
      req = 4'b1111;
      settle();
      tests++; if (rvalid !== 4'b1000) begin fails++; $display("FAIL mid_rvalid_pre: got %b want 1000", rvalid); end
      reset = 1;
      #1;
      tests++; if (rvalid !== 4'b0000) begin fails++; $display("FAIL mid_rvalid_rst: got %b want 0000", rvalid); end
      tests++; if (gnt !== 4'b0000 || mem_En !== 1'b0) begin fails++; $display("FAIL mid_gnt_rst: got %b/%b want 0000/0", gnt, mem_En); end
      advance();
      reset = 0; req = 4'b0010;
      settle();
      tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL mid_post_gnt: got %b want 0010", gnt); end
      tests++; if (rvalid !== 4'b0000) begin fails++; $display("FAIL mid_post_rvalid: got %b want 0000", rvalid); end
      advance();
      req = '0;
      settle();
      tests++; if (rvalid !== 4'b0010) begin fails++; $display("FAIL mid_new_rvalid: got %b want 0010", rvalid); end
      advance();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 800; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         req   = 4'($urandom | $urandom);
         wren  = 4'($urandom);
         lock  = 4'($urandom | $urandom);
         for (int i = 0; i < 4; i++) begin
            addr[32*i +: 32]  = 32'($urandom_range(0, 15)) << 3;
            wdata[64*i +: 64] = {$urandom, $urandom};
         end
         settle();
         tests++; if (gnt !== e_gnt) begin fails++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, e_gnt); end
         tests++; if ({mem_En, mem_WrEn} !== {e_en, e_we}) begin fails++; $display("FAIL rnd_en c%0d: got %b%b want %b%b", c, mem_En, mem_WrEn, e_en, e_we); end
         tests++; if (mem_addr !== e_addr) begin fails++; $display("FAIL rnd_addr c%0d: got %h want %h", c, mem_addr, e_addr); end
         tests++; if (mem_d_in !== e_din) begin fails++; $display("FAIL rnd_d_in c%0d: got %h want %h", c, mem_d_in, e_din); end
         tests++; if (rvalid !== e_rvalid) begin fails++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, rvalid, e_rvalid); end
         tests++; if (rdata !== e_rdata) begin fails++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, rdata, e_rdata); end
         advance();
      end
   endtask

   initial begin
      reset = 1; req = '0; wren = '0; lock = '0;
      addr = '0; wdata = '0;
      for (int i = 0; i < 4; i++) begin
         addr[32*i +: 32]  = 32'h100 + 32'(i * 8);
         wdata[64*i +: 64] = 64'hA000 + 64'(i);
      end
      test_reset();
      test_rotation();
      test_single_read();
      test_write();
      test_lock_burst();
      test_lock_release();
      test_reset_mid_read();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmem_rr_arbiter.md
# dmem_rr_arbiter

Round-robin arbiter that shares one single-port 64-bit data memory among four requesters, e.g. four cardinal CPU cores or CPU plus NIC DMA engines in a multi-core build. It grants at most one request per cycle, drives the memory port combinationally in the grant cycle, and routes read data back one cycle later with a per-requester valid. A bounded lock mechanism lets a requester hold the memory for back-to-back bursts without starving the others.

## Interface
Parameters:
- MAX_BURST, 4: maximum consecutive locked grants to one requester before forced rotation (legal range 1–15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  [0:3]  request per requester; bit i = requester i.
- wren  input  [0:3]  1 = write, 0 = read, qualified by req.
- lock  input  [0:3]  request to keep ownership on the next cycle.
- addr  input  [0:127]  requester i address at bits [32i : 32i+31].
- wdata  input  [0:255]  requester i write data at bits [64i : 64i+63].
- gnt  output  [0:3]  one-hot or zero grant, combinational from req/state.
- rvalid  output  [0:3]  read data valid for requester i, registered.
- rdata  output  [0:63]  read data, shared by all requesters, qualified by rvalid.
- mem_En  output  1  memory enable (= |gnt).
- mem_WrEn  output  1  memory write enable (wren of granted requester).
- mem_addr  output  [0:31]  granted address.
- mem_d_in  output  [0:63]  granted write data.
- mem_d_out  input  [0:63]  memory read data, valid one cycle after a read enable.

## Operation
- State: ptr (2 bits, highest-priority index), owner (2 bits), burst_cnt (4 bits), FSM {ARB, LOCKED}.
- ARB: search req starting at ptr, ascending, wrapping 3→0; the first asserted bit wins. No req → gnt = 0, memory idle, ptr unchanged.
- On a grant to i in ARB: ptr <= (i+1) mod 4. If lock[i]=1 and MAX_BURST>1 → LOCKED, owner <= i, burst_cnt <= 1.
- LOCKED: if req[owner]=1, the owner is granted regardless of other requests, and burst_cnt increments.
  - Exit to ARB after this grant if lock[owner]=0 or burst_cnt+1 == MAX_BURST.
  - If req[owner]=0: exit to ARB immediately in the same cycle and arbitrate normally from ptr (already owner+1). No idle bubble.
- Memory outputs are muxed from the granted requester. When gnt=0: mem_En=0, mem_WrEn=0, mem_addr=0, mem_d_in=0.
- Read return: a granted read (wren=0) sets rvalid[i] for exactly the next cycle, with rdata = mem_d_out. Writes produce no rvalid. At most one rvalid bit is set.
- Requesters must hold req/addr/wdata stable only in the cycle they sample gnt. An ungranted request simply stays asserted.

## Timing
- Reset (asynchronous, any cycle) sets ptr=0, FSM=ARB, owner=0, burst_cnt=0, rvalid=0, and rdata=0.
  - While reset is high, gnt=0 and mem_En=0 (gnt is forced low).
  - An in-flight read is dropped: no rvalid after reset deasserts.
- Grant latency is 0 cycles (gnt in the same cycle as req). Read latency is 1 cycle (rvalid the cycle after gnt).
- Throughput is one access per cycle. Back-to-back reads from different requesters give consecutive rvalid bits, each paired with its own cycle's mem_d_out.
- Worst-case wait for a requester: 3 × MAX_BURST cycles of other grants.
- A simultaneous request from the owner and others in LOCKED goes to the owner. When LOCKED exits on the MAX_BURST limit, the next grant goes to the next requester after the owner.
- A lock asserted by a requester that was not granted is ignored.

## Test plan
- After reset, req=4'b1111 held, no lock → gnt sequence 1000, 0100, 0010, 0001, 1000. mem_addr follows each requester's address.
- Single read: requester 2 reads addr 0x40, memory returns 0xDEAD_BEEF_0000_0001 → gnt=0010 in cycle N; rvalid=0010 and rdata=0xDEADBEEF00000001 in N+1; rvalid=0 in N+2.
- Write: requester 3 with wren=1, wdata=0x1234 → mem_En=1, mem_WrEn=1, mem_d_in=0x1234 in the grant cycle; rvalid stays 0.
- Lock with MAX_BURST=4: requester 0 holds lock=1 and req=1, others request continuously → 4 consecutive grants to 0, then grant to 1, 2, 3, 0.
- Lock released early: requester 1 is locked, then drops req in cycle 2 while requester 3 requests → gnt=0001 in that same cycle; FSM is in ARB.
- Reset mid-read: assert reset in the cycle after a read grant → rvalid=0, gnt=0 immediately. After release, req=4'b0010 is granted in the first cycle.
